// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, buffer sizing and PC helper for the fetch sequencer
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000033;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;

    function automatic logic [XLEN-1:0] wrap_pc(input logic [XLEN-1:0] a, input logic [XLEN-1:0] limit);
        return a & (limit - XLEN'(1)) & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of {pc, instr} with flush; head is always registered
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    buf_state_t   state_q, state_d;
    fetch_entry_t mem_q [FETCH_BUF_DEPTH];
    logic         rd_q, wr_q;

    always_comb begin
        state_d = state_q;
        if (flush) state_d = EMPTY;
        else if (push && !pop) state_d = (state_q == EMPTY) ? ONE : FULL;
        else if (pop && !push) state_d = (state_q == FULL) ? ONE : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= din;
                    wr_q        <= ~wr_q;
                end
                if (pop) rd_q <= ~rd_q;
            end
        end
    end

    assign head  = mem_q[rd_q];
    assign count = state_q;

    // The issue rule upstream must keep a full buffer from ever seeing a push
    assert property (@(posedge clk) disable iff (!rst_n) !(state_q == FULL && push && !flush));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer issuing imem reads and buffering returns for decode
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = 4,
    parameter int ADDR_LIMIT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_data,
    output logic [WIDTH-1:0] instr_pc
);
    logic [WIDTH-1:0] pc_q, inflight_pc_q;
    logic             inflight_q, issue, push, pop;
    logic [1:0]       count;
    fetch_entry_t     head;

    assign pop  = instr_valid & instr_ready;
    assign push = inflight_q & ~redirect_valid;
    // Reserve a slot for the in-flight word so a stalled consumer never overflows the buffer
    assign issue = en & ~redirect_valid & ((3'(count) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= WIDTH'(RESET_PC);
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
            if (redirect_valid) pc_q <= wrap_pc(redirect_pc, XLEN'(ADDR_LIMIT));
            else if (issue) pc_q <= wrap_pc(pc_q + WIDTH'(PC_STEP), XLEN'(ADDR_LIMIT));
        end
    end

    fetch_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: inflight_pc_q, instr: imem_rdata}),
        .head  (head),
        .count (count)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = count != 2'd0;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of streaming, stall, redirect, wrap, enable and async reset
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, en, redirect_valid, instr_ready, instr_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_data, instr_pc;
    logic [31:0] mem [64];
    int          errors = 0, checks = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] data);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_data"}, instr_data, data);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        en = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        rst_n = 1'b1;
        en = 1'b1;
        instr_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
        mem[0]  = 32'h00000033;
        mem[1]  = 32'h00638433;
        mem[2]  = 32'h406384b3;
        mem[10] = 32'h0063f8b3;
        rst_n = 1'b0;
        en = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_data", instr_data, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        // streaming
        restart();
        step();
        check("str_c1_valid", 32'(instr_valid), 32'd0);
        check("str_c1_addr", imem_addr, 32'd4);
        step();
        head("str0", 32'd0, 32'h00000033);
        step();
        head("str4", 32'd4, 32'h00638433);
        step();
        head("str8", 32'd8, 32'h406384b3);

        // backpressure
        restart();
        step();
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            head("bp_hold", 32'd0, 32'h00000033);
            check("bp_addr", imem_addr, 32'd8);
        end
        for (int i = 0; i < 5; i++) step();
        check("bp_count", {30'b0, dut.count}, 32'd2);
        head("bp_hold_end", 32'd0, 32'h00000033);
        check("bp_addr_end", imem_addr, 32'd8);
        instr_ready = 1'b1;
        step();
        head("bp4", 32'd4, 32'h00638433);
        step();
        head("bp8", 32'd8, 32'h406384b3);
        step();
        head("bp12", 32'd12, 32'h1000000c);

        // redirect to an unaligned target while streaming
        restart();
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'd42;
        step();
        redirect_valid = 1'b0;
        check("rd_valid0", 32'(instr_valid), 32'd0);
        check("rd_addr", imem_addr, 32'd40);
        step();
        check("rd_valid1", 32'(instr_valid), 32'd0);
        step();
        head("rd40", 32'd40, 32'h0063f8b3);
        step();
        head("rd44", 32'd44, 32'h1000002c);

        // wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'd252;
        step();
        redirect_valid = 1'b0;
        check("wr_addr", imem_addr, 32'd252);
        check("wr_valid0", 32'(instr_valid), 32'd0);
        step();
        check("wr_addr_wrap", imem_addr, 32'd0);
        step();
        head("wr252", 32'd252, 32'h100000fc);
        step();
        head("wr0", 32'd0, 32'h00000033);
        step();
        head("wr4", 32'd4, 32'h00638433);

        // enable low drains the pipeline, then resumes from pc
        restart();
        step();
        step();
        head("en0", 32'd0, 32'h00000033);
        en = 1'b0;
        step();
        head("en4", 32'd4, 32'h00638433);
        check("en_addr", imem_addr, 32'd8);
        step();
        check("en_drain_valid", 32'(instr_valid), 32'd0);
        step();
        check("en_idle_valid", 32'(instr_valid), 32'd0);
        check("en_idle_addr", imem_addr, 32'd8);
        en = 1'b1;
        step();
        check("en_resume_valid", 32'(instr_valid), 32'd0);
        step();
        head("en8", 32'd8, 32'h406384b3);

        // asynchronous reset mid-stream
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_addr", imem_addr, 32'd0);
        check("arst_pc", instr_pc, 32'd0);
        check("arst_data", instr_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the synchronous instruction memory (1-cycle registered read, byte-addressed, 256 locations).
- Owns the PC, issues one read per cycle and tracks the in-flight read.
- Captures returned words into a 2-entry buffer and presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing stale data; sits between the instruction memory and the decode stage.

Parameters:
WIDTH, 32, data/address width
RESET_PC, 0, PC value loaded at reset
PC_STEP, 4, byte increment per sequential fetch
ADDR_LIMIT, 256, memory span in bytes; power of 2; PC wraps modulo ADDR_LIMIT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  fetch enable; low = no new reads issued
redirect_valid  in  1  load new PC this cycle, flush pipeline
redirect_pc  in  WIDTH  redirect target (byte address)
imem_addr  out  WIDTH  read address to instruction memory (= pc_q)
imem_rdata  in  WIDTH  read data, valid the cycle after the address was issued
instr_valid  out  1  buffer head valid
instr_ready  in  1  decode accepts head
instr_data  out  WIDTH  head instruction word
instr_pc  out  WIDTH  head instruction address

Behaviour:
- Reset (async assert, sync deassert by design):
  - pc_q=RESET_PC, inflight_q=0, buffer empty.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - imem_addr=RESET_PC.
- Handshake:
  - pop = instr_valid & instr_ready.
  - instr_valid/data/pc are driven from buffer registers only; no combinational path from imem_rdata.
  - Held stable while valid & !ready.
- Issue rule:
  - issue = en & !redirect_valid & (count + inflight_q - pop < 2), where count ∈ {0,1,2}.
  - On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=(pc_q+PC_STEP) mod ADDR_LIMIT.
  - Else: inflight_q<=0.
- Capture:
  - When inflight_q=1 and no redirect, push {inflight_pc_q, imem_rdata} into the buffer.
  - The issue rule guarantees the push never overflows.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Latency and throughput:
  - Address presented at cycle t → instr_valid at cycle t+2.
  - Sustains 1 instr/cycle with instr_ready held high.
- Stall: with instr_ready low, at most 2 instructions are buffered; issue halts; no data is lost or duplicated.
- Redirect (highest priority):
  - pc_q<=(redirect_pc & ~3) mod ADDR_LIMIT.
  - Buffer cleared; inflight_q<=0; the response arriving in the redirect cycle is discarded.
  - No issue in the redirect cycle.
  - A pop in the same cycle still completes (the consumer took the old head).
  - instr_valid=0 the next cycle.
  - First fetch from the new target at cycle r+1; valid at r+3.
- Enable:
  - en low stops issue only; an in-flight read still lands and the buffer still drains.
  - en rising resumes from pc_q.
- Wrap: pc (ADDR_LIMIT-PC_STEP) is followed by 0.
- Reset mid-operation: immediately returns all state to reset values; in-flight data is dropped.
- Buffer states: EMPTY (count=0), ONE (1), FULL (2).
  - Transitions: push & !pop (+1), pop & !push (−1), redirect → EMPTY.
  - FULL & push is unreachable; flag it with an assertion.

Decomposition:
- fetch_pkg holds:
  - fetch_entry_t struct {pc, instr}.
  - FETCH_BUF_DEPTH=2.
  - INSTR_NOP=32'h00000033.
  - Helper function for the aligned/wrapped next-PC.
- Sub-module fetch_buf: 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, head. fetch_ctrl instantiates it.

Test Plan:
- Common setup: memory model with 1-cycle registered read, preloaded mem[0]=32'h00000033, mem[4]=32'h00638433, mem[8]=32'h406384b3, mem[40]=32'h0063f8b3.
- Streaming: release reset, en=1, instr_ready=1 → instr_valid rises on cycle 2; pairs (0,00000033), (4,00638433), (8,406384b3) on consecutive cycles.
- Backpressure: instr_ready=0 for 5 cycles after the first valid → head stays (0,00000033), count=2, imem_addr stops advancing at 8. Release ready → 0, 4, 8 delivered with no gap or duplicate.
- Redirect: redirect_valid with redirect_pc=42 while streaming → next cycle instr_valid=0; 2 cycles later head=(40,0063f8b3); the in-flight stale word is never output.
- Wrap: redirect to 252, ready=1 → instr_pc sequence 252, 0, 4.
- Enable/reset: en=0 mid-stream → at most 1 further push, then valid drops after drain. Assert rst_n low mid-stream → instr_valid=0 and imem_addr=0 immediately (asynchronous).
